// File: rtl/alu_acc_pkg.sv
// Shared types and constants for the ALU result/accumulator stage.
package alu_acc_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_ADD   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RESULT = 1'b1
    } state_t;

    localparam int ACC_W = 8;

endpackage

// File: rtl/acc_add.sv
// Ripple-carry adder with carry-out for the accumulate path.
// It is built from the same FA cell that the upstream ALU uses.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module acc_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/alu_acc_reg.sv
// Result/accumulator stage behind the 4-bit ALU: valid/ready capture, mode
// apply (load/add/hold/clear), sticky overflow and saturating op counter.
module alu_acc_reg
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = ACC_W,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       b_feedback,
    output logic             ovf,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             accept;

    acc_add #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (alu_in),
        .sum  (sum),
        .cout (carry)
    );

    // mode/alu_in are only looked at under accept, so X outside it is harmless
    assign accept = (state_q == S_IDLE) && in_valid;

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid)  state_d = S_RESULT;
            S_RESULT: if (out_ready) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_RESULT);
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            unique case (mode_t'(mode))
                MODE_LOAD:  acc_d = alu_in;
                MODE_ADD: begin
                    acc_d = sum;
                    ovf_d = ovf_q | carry;
                end
                MODE_CLEAR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign acc        = acc_q;
    assign ovf        = ovf_q;
    assign op_count   = cnt_q;
    assign b_feedback = acc_q[3:0];

endmodule
